spi_flash_resp: RTL and testbench
=================================

// Module: spi_flash_resp
// PURPOSE
//  SPI mode-0 slave emulating a small serial NOR flash; the responder end of the SoC SPI0 master link
//  (spi0_cs/spi0_clk/spi0_mosi out, spi0_miso in). Synthesisable replacement for the behavioural flash
//  model in SoC benches and FPGA builds. SPI pins are oversampled in the clk domain; byte storage is internal.
// PARAMETERS
//  AW        12         byte address width used internally; DEPTH = 2**AW bytes
//  JEDEC_ID  24'hEF4018 3-byte ID returned by 0x9F, MSB byte first
// PORTS
//  clk          in   1   system clock; SCK half-period must be >= 4 clk
//  rst_n        in   1   async active-low reset
//  spi_cs_n     in   1   chip select, active low
//  spi_sck      in   1   SPI clock, CPOL=0
//  spi_mosi     in   1   master out
//  spi_miso     out  1   slave out, MSB first
//  spi_miso_oe  out  1   1 = drive spi_miso; pad tri-stated when 0
//  wel          out  1   write-enable latch
//  cmd_done     out  1   1-clk pulse when CS deasserts after >= 8 SCK rising edges
// BEHAVIOUR
//  Reset: spi_miso=0, spi_miso_oe=0, wel=0, cmd_done=0, FSM=IDLE. Memory is not reset; it initialises to 8'hFF.
//  Sync: cs_n, sck and mosi pass through 2-FF synchronisers, and SCK edges are detected on the synced
//   copy. All actions occur 3 clk after the pin event.
//  Shifting: bits are sampled on SCK rise into rx_sr. The bit counter is 0..7, and the 8th rise completes a byte.
//   spi_miso updates on SCK fall from tx_sr[7], then tx_sr shifts left.
//   tx_sr loads the next response byte on the 8th rise, so its MSB is on spi_miso before the next rise.
//  spi_miso_oe=1 only in RD_DATA, RD_ID and RD_SR; otherwise it is 0.
//  FSM states: IDLE, CMD, ADDR, RD_DATA, WR_DATA, RD_ID, RD_SR, IGNORE.
//   IDLE -> CMD on CS fall. CMD decodes the first byte:
//    0x03 -> ADDR(read)
//    0x02 -> ADDR(prog)
//    0x9F -> RD_ID
//    0x05 -> RD_SR
//    0x06: set wel at CS rise -> IGNORE
//    0x04: clear wel at CS rise -> IGNORE
//    other -> IGNORE
//   ADDR collects 3 bytes MSB-first into a 24-bit register; only the low AW bits are used.
//   After the 3rd byte it goes to RD_DATA (tx_sr = mem[addr]) or WR_DATA.
//  RD_DATA: addr increments after each byte and wraps from DEPTH-1 to 0.
//  RD_ID: returns JEDEC_ID[23:16], [15:8], [7:0], then repeats 8'h00.
//  RD_SR: repeats {6'b0, wel, 1'b0} (BUSY is always 0).
//  WR_DATA: on each 8th rise, if wel=1 then mem[addr] <= mem[addr] & rx byte (NOR semantics: only 1->0).
//   addr[7:0] then increments and wraps inside the 256-byte page; the upper bits are unchanged.
//   If wel=0, bytes are discarded. At CS rise after a 0x02 command, wel is cleared.
//  CS rise in any state: FSM -> IDLE, bit counter cleared, spi_miso_oe=0, any partial byte discarded.
//   cmd_done pulses if at least one full byte was received.
//  CS rise coinciding with the 8th SCK rise: the byte completes first, then the abort takes effect.
//  SCK edges while CS is high are ignored. rst_n mid-transfer: immediate return to the reset state, memory retained.
// TESTING
//  1. 0x9F followed by 24 clocks -> MISO bytes EF,40,18; then 8 more clocks -> 00; cmd_done pulses once.
//  2. 0x05 -> 00. Then 0x06 and CS high -> wel=1. Then 0x05 -> 02.
//  3. 0x06; then 0x02 000010 with bytes A5,3C -> mem[0x10]=A5, mem[0x11]=3C, wel=0 after CS rise.
//     Then 0x03 000010 reading 3 bytes -> A5,3C,FF.
//  4. Program with wel=0: 0x02 000020 with byte 00 -> mem[0x20] stays FF.
//     Page wrap: wel=1, 0x02 0000FF with bytes 11,22 -> mem[0xFF]=11, mem[0x00]=22.
//  5. Read wrap: 0x03 000FFF reading 2 bytes -> mem[0xFFF], mem[0x000]. Address 0x123FFF aliases to 0xFFF.
//  6. Abort: CS rise after 4 bits of a program byte -> no write, oe=0.
//     rst_n low mid-read -> miso=0, oe=0; the next 0x03 returns the stored data unchanged.

Source files
------------

// File: rtl/spi_flash_resp.sv
// SPI mode-0 serial NOR flash responder. SPI pins are oversampled in the clk domain.
// Supports READ 03, PROGRAM 02, RDID 9F, RDSR 05, WREN 06 and WRDI 04 on an internal 2**AW byte array.
module spi_flash_resp #(
    parameter int          AW       = 12,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_cs_n,
    input  logic spi_sck,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    output logic wel,
    output logic cmd_done
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_RD_DATA, ST_WR_DATA, ST_RD_ID, ST_RD_SR, ST_IGNORE
    } state_t;

    state_t        state_q, state_d;
    logic          cs_s1_q, cs_s2_q, cs_prev_q;
    logic          sck_s1_q, sck_s2_q, sck_prev_q;
    logic          mosi_s1_q, mosi_s2_q;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    rx_sr_q, rx_sr_d;
    logic [7:0]    tx_sr_q, tx_sr_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    addr_cnt_q, addr_cnt_d;
    logic [1:0]    id_idx_q, id_idx_d;
    logic          byte_seen_q, byte_seen_d;
    logic          miso_q, miso_d;
    logic          oe_q, oe_d;
    logic          wel_q, wel_d;
    logic          cmd_done_q, cmd_done_d;

    // Flash contents come up erased and are never touched by reset.
    logic [7:0]    mem_q [DEPTH] = '{default: 8'hFF};

    logic          mem_we_s;
    logic [AW-1:0] mem_waddr_s;
    logic [7:0]    mem_wdata_s;
    logic          sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s, byte_done_s;
    logic [7:0]    rx_new_s, cmd_eff_s, sr_byte_s;
    logic [AW-1:0] addr_shift_s, addr_inc_s;

    assign sck_rise_s   = sck_s2_q & ~sck_prev_q;
    assign sck_fall_s   = ~sck_s2_q & sck_prev_q;
    assign cs_fall_s    = cs_prev_q & ~cs_s2_q;
    assign cs_rise_s    = ~cs_prev_q & cs_s2_q;
    assign rx_new_s     = {rx_sr_q, mosi_s2_q};
    assign byte_done_s  = (state_q != ST_IDLE) && sck_rise_s && (bit_cnt_q == 3'd7);
    // The 24-bit address is shifted in MSB-first; only its low AW bits are kept.
    assign addr_shift_s = AW'({addr_q, rx_new_s});
    assign addr_inc_s   = addr_q + {{(AW-1){1'b0}}, 1'b1};
    assign sr_byte_s    = {6'b000000, wel_q, 1'b0};
    assign cmd_eff_s    = ((state_q == ST_CMD) && byte_done_s) ? rx_new_s : cmd_q;

    // Two-flop synchronisers plus one extra stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s1_q    <= 1'b1;
            cs_s2_q    <= 1'b1;
            cs_prev_q  <= 1'b1;
            sck_s1_q   <= 1'b0;
            sck_s2_q   <= 1'b0;
            sck_prev_q <= 1'b0;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
        end else begin
            cs_s1_q    <= spi_cs_n;
            cs_s2_q    <= cs_s1_q;
            cs_prev_q  <= cs_s2_q;
            sck_s1_q   <= spi_sck;
            sck_s2_q   <= sck_s1_q;
            sck_prev_q <= sck_s2_q;
            mosi_s1_q  <= spi_mosi;
            mosi_s2_q  <= mosi_s1_q;
        end
    end

    // Next-state, shifting, command decode and memory write control.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        addr_cnt_d  = addr_cnt_q;
        id_idx_d    = id_idx_q;
        byte_seen_d = byte_seen_q;
        miso_d      = miso_q;
        wel_d       = wel_q;
        cmd_done_d  = 1'b0;
        oe_d        = 1'b0;
        mem_we_s    = 1'b0;
        mem_waddr_s = addr_q;
        mem_wdata_s = mem_q[addr_q] & rx_new_s;

        if (state_q == ST_IDLE) begin
            if (cs_fall_s) begin
                state_d     = ST_CMD;
                bit_cnt_d   = 3'd0;
                byte_seen_d = 1'b0;
                cmd_d       = 8'h00;
                addr_cnt_d  = 2'd0;
            end else begin
                bit_cnt_d   = 3'd0;
            end
        end else begin
            if (sck_fall_s) begin
                miso_d  = tx_sr_q[7];
                tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end else if (sck_rise_s) begin
                rx_sr_d   = rx_new_s[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (byte_done_s) begin
                    byte_seen_d = 1'b1;
                    case (state_q)
                        ST_CMD: begin
                            cmd_d = rx_new_s;
                            case (rx_new_s)
                                8'h03, 8'h02: begin
                                    state_d    = ST_ADDR;
                                    addr_cnt_d = 2'd0;
                                end
                                8'h9F: begin
                                    state_d  = ST_RD_ID;
                                    tx_sr_d  = JEDEC_ID[23:16];
                                    id_idx_d = 2'd1;
                                end
                                8'h05: begin
                                    state_d = ST_RD_SR;
                                    tx_sr_d = sr_byte_s;
                                end
                                default: state_d = ST_IGNORE;
                            endcase
                        end
                        ST_ADDR: begin
                            addr_d = addr_shift_s;
                            if (addr_cnt_q == 2'd2) begin
                                if (cmd_q == 8'h03) begin
                                    state_d = ST_RD_DATA;
                                    tx_sr_d = mem_q[addr_shift_s];
                                end else begin
                                    state_d = ST_WR_DATA;
                                end
                            end else begin
                                addr_cnt_d = addr_cnt_q + 2'd1;
                            end
                        end
                        ST_RD_DATA: begin
                            addr_d  = addr_inc_s;
                            tx_sr_d = mem_q[addr_inc_s];
                        end
                        ST_WR_DATA: begin
                            mem_we_s    = wel_q;
                            addr_d[7:0] = addr_q[7:0] + 8'd1;
                        end
                        ST_RD_ID: begin
                            case (id_idx_q)
                                2'd1: begin
                                    tx_sr_d  = JEDEC_ID[15:8];
                                    id_idx_d = 2'd2;
                                end
                                2'd2: begin
                                    tx_sr_d  = JEDEC_ID[7:0];
                                    id_idx_d = 2'd3;
                                end
                                default: tx_sr_d = 8'h00;
                            endcase
                        end
                        ST_RD_SR: tx_sr_d = sr_byte_s;
                        default: tx_sr_d = tx_sr_q;
                    endcase
                end else begin
                    byte_seen_d = byte_seen_q;
                end
            end else begin
                miso_d = miso_q;
            end

            // A byte finishing on the same edge as CS rise is completed above, then aborted here.
            if (cs_rise_s) begin
                state_d    = ST_IDLE;
                bit_cnt_d  = 3'd0;
                cmd_done_d = byte_seen_q | byte_done_s;
                case (cmd_eff_s)
                    8'h06:        wel_d = 1'b1;
                    8'h04, 8'h02: wel_d = 1'b0;
                    default:      wel_d = wel_q;
                endcase
            end else begin
                cmd_done_d = 1'b0;
            end
        end

        case (state_d)
            ST_RD_DATA, ST_RD_ID, ST_RD_SR: oe_d = 1'b1;
            default:                        oe_d = 1'b0;
        endcase
    end

    // Protocol state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            rx_sr_q     <= 7'd0;
            tx_sr_q     <= 8'h00;
            cmd_q       <= 8'h00;
            addr_q      <= {AW{1'b0}};
            addr_cnt_q  <= 2'd0;
            id_idx_q    <= 2'd0;
            byte_seen_q <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            wel_q       <= 1'b0;
            cmd_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            addr_cnt_q  <= addr_cnt_d;
            id_idx_q    <= id_idx_d;
            byte_seen_q <= byte_seen_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            wel_q       <= wel_d;
            cmd_done_q  <= cmd_done_d;
        end
    end

    // Byte array write port; deliberately outside reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign wel         = wel_q;
    assign cmd_done    = cmd_done_q;
endmodule

// File: tb/tb_spi_flash_resp.sv
// Self-checking bench for spi_flash_resp: an SPI mode-0 master task drives transactions and a
// byte-level flash model (array + WEL flag) predicts MISO bytes, output enable, WEL and cmd_done.
module tb_spi_flash_resp;
    localparam int HALF = 5;

    logic clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, sck = 1'b0, mosi = 1'b0;
    logic miso, miso_oe, wel, cmd_done;

    int chk_cnt = 0, pass_cnt = 0, done_cnt = 0, done_pulses = 0, exp_done = 0;
    logic [7:0] mdl_mem [4096];
    logic       mdl_wel = 1'b0;
    logic [7:0] tx_q[$], rx_q[$], exp_q[$];
    logic       care_q[$], oe_q[$], eoe_q[$];

    spi_flash_resp dut (
        .clk(clk), .rst_n(rst_n), .spi_cs_n(cs_n), .spi_sck(sck), .spi_mosi(mosi),
        .spi_miso(miso), .spi_miso_oe(miso_oe), .wel(wel), .cmd_done(cmd_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (cmd_done === 1'b1) done_cnt++;

    task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] r, output logic oe_mid);
        r = 8'h00;
        oe_mid = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            r = {r[6:0], miso};
            if (i == 4) oe_mid = miso_oe;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    // Flash behaviour at transaction level: decode command, address, data bytes.
    task automatic model_txn();
        logic [7:0] c, e;
        logic       cr, oe;
        int         a;
        exp_q.delete(); care_q.delete(); eoe_q.delete();
        c = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        a = 0;
        if (tx_q.size() >= 4) a = int'({tx_q[1], tx_q[2], tx_q[3]}) % 4096;
        for (int i = 0; i < tx_q.size(); i++) begin
            e = 8'h00; cr = 1'b0; oe = 1'b0;
            if (i >= 1 && c == 8'h9F) begin
                cr = 1'b1; oe = 1'b1;
                e = (i == 1) ? 8'hEF : (i == 2) ? 8'h40 : (i == 3) ? 8'h18 : 8'h00;
            end else if (i >= 1 && c == 8'h05) begin
                cr = 1'b1; oe = 1'b1; e = mdl_wel ? 8'h02 : 8'h00;
            end else if (i >= 4 && c == 8'h03) begin
                cr = 1'b1; oe = 1'b1; e = mdl_mem[a]; a = (a + 1) % 4096;
            end else if (i >= 4 && c == 8'h02) begin
                if (mdl_wel) mdl_mem[a] = mdl_mem[a] & tx_q[i];
                a = (a / 256) * 256 + (a + 1) % 256;
            end
            exp_q.push_back(e); care_q.push_back(cr); eoe_q.push_back(oe);
        end
        if (tx_q.size() > 0) begin
            if (c == 8'h06) mdl_wel = 1'b1;
            else if (c == 8'h04 || c == 8'h02) mdl_wel = 1'b0;
        end
        exp_done = (tx_q.size() > 0) ? 1 : 0;
    endtask

    task automatic run_txn(input int extra_bits);
        logic [7:0] r;
        logic       o;
        int         d0;
        rx_q.delete(); oe_q.delete();
        d0 = done_cnt;
        @(negedge clk) cs_n = 1'b0;
        foreach (tx_q[i]) begin
            spi_byte(tx_q[i], 8, r, o);
            rx_q.push_back(r); oe_q.push_back(o);
        end
        if (extra_bits > 0) spi_byte(8'($urandom), extra_bits, r, o);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        done_pulses = done_cnt - d0;
        model_txn();
    endtask

    task automatic test_reset();
        chk_cnt++; if ({miso, miso_oe, wel, cmd_done} !== 4'b0000) $display("FAIL reset_outputs: got %b expected 0000", {miso, miso_oe, wel, cmd_done}); else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_cnt++; if ({miso_oe, wel, cmd_done} !== 3'b000) $display("FAIL after_reset: got %b expected 000", {miso_oe, wel, cmd_done}); else pass_cnt++;
    endtask

    task automatic test_id_status();
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: tx_q = '{8'h9F, 8'h00, 8'h00, 8'h00, 8'h00};
                1: tx_q = '{8'h05, 8'h00, 8'h00};
                2: tx_q = '{8'h06};
                3: tx_q = '{8'h05, 8'h00};
                4: tx_q = '{8'h04};
                default: tx_q = '{8'h05, 8'h00};
            endcase
            run_txn(0);
            for (int i = 0; i < rx_q.size(); i++) begin
                if (care_q[i]) begin
                    chk_cnt++; if (rx_q[i] !== exp_q[i]) $display("FAIL id_status miso k=%0d byte %0d: got %h expected %h", k, i, rx_q[i], exp_q[i]); else pass_cnt++;
                end
                chk_cnt++; if (oe_q[i] !== eoe_q[i]) $display("FAIL id_status oe k=%0d byte %0d: got %b expected %b", k, i, oe_q[i], eoe_q[i]); else pass_cnt++;
            end
            chk_cnt++; if (wel !== mdl_wel) $display("FAIL id_status wel k=%0d: got %b expected %b", k, wel, mdl_wel); else pass_cnt++;
            chk_cnt++; if (done_pulses !== exp_done) $display("FAIL id_status cmd_done k=%0d: got %0d expected %0d", k, done_pulses, exp_done); else pass_cnt++;
            chk_cnt++; if (miso_oe !== 1'b0) $display("FAIL id_status oe_idle k=%0d: got %b expected 0", k, miso_oe); else pass_cnt++;
        end
    endtask

    task automatic test_program_read();
        for (int k = 0; k < 11; k++) begin
            case (k)
                0: tx_q = '{8'h06};
                1: tx_q = '{8'h02, 8'h00, 8'h00, 8'h10, 8'hA5, 8'h3C};
                2: tx_q = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
                3: tx_q = '{8'h02, 8'h00, 8'h00, 8'h20, 8'h00};
                4: tx_q = '{8'h03, 8'h00, 8'h00, 8'h20, 8'h00};
                5: tx_q = '{8'h06};
                6: tx_q = '{8'h02, 8'h00, 8'h00, 8'hFF, 8'h11, 8'h22};
                7: tx_q = '{8'h03, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
                8: tx_q = '{8'h06};
                9: tx_q = '{8'h02, 8'h00, 8'h00, 8'h10, 8'h0F};
                default: tx_q = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
            endcase
            run_txn(0);
            for (int i = 0; i < rx_q.size(); i++) begin
                if (care_q[i]) begin
                    chk_cnt++; if (rx_q[i] !== exp_q[i]) $display("FAIL prog_read miso k=%0d byte %0d: got %h expected %h", k, i, rx_q[i], exp_q[i]); else pass_cnt++;
                end
                chk_cnt++; if (oe_q[i] !== eoe_q[i]) $display("FAIL prog_read oe k=%0d byte %0d: got %b expected %b", k, i, oe_q[i], eoe_q[i]); else pass_cnt++;
            end
            chk_cnt++; if (wel !== mdl_wel) $display("FAIL prog_read wel k=%0d: got %b expected %b", k, wel, mdl_wel); else pass_cnt++;
            chk_cnt++; if (done_pulses !== exp_done) $display("FAIL prog_read cmd_done k=%0d: got %0d expected %0d", k, done_pulses, exp_done); else pass_cnt++;
        end
    endtask

    task automatic test_read_wrap();
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: tx_q = '{8'h06};
                1: tx_q = '{8'h02, 8'h00, 8'h0F, 8'hFF, 8'h5A};
                2: tx_q = '{8'h03, 8'h00, 8'h0F, 8'hFF, 8'h00, 8'h00};
                default: tx_q = '{8'h03, 8'h12, 8'h3F, 8'hFF, 8'h00};
            endcase
            run_txn(0);
            for (int i = 0; i < rx_q.size(); i++) begin
                if (care_q[i]) begin
                    chk_cnt++; if (rx_q[i] !== exp_q[i]) $display("FAIL read_wrap miso k=%0d byte %0d: got %h expected %h", k, i, rx_q[i], exp_q[i]); else pass_cnt++;
                end
            end
            chk_cnt++; if (wel !== mdl_wel) $display("FAIL read_wrap wel k=%0d: got %b expected %b", k, wel, mdl_wel); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int op, a, r, n;
        for (int k = 0; k < 30; k++) begin
            op = $urandom_range(0, 3);
            a  = (($urandom_range(0, 1) == 0) ? 12'h0F8 : 12'hFF8) + $urandom_range(0, 15);
            r  = $urandom;
            n  = $urandom_range(1, 4);
            case (op)
                0: tx_q = '{8'h06};
                1: tx_q = '{8'h04};
                2: tx_q = '{8'h02, r[7:0], {r[11:8], 4'(a >> 8)}, 8'(a)};
                default: tx_q = '{8'h03, r[7:0], {r[11:8], 4'(a >> 8)}, 8'(a)};
            endcase
            if (op >= 2) for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
            run_txn(0);
            for (int i = 0; i < rx_q.size(); i++) begin
                if (care_q[i]) begin
                    chk_cnt++; if (rx_q[i] !== exp_q[i]) $display("FAIL random miso k=%0d byte %0d: got %h expected %h", k, i, rx_q[i], exp_q[i]); else pass_cnt++;
                end
            end
            chk_cnt++; if (wel !== mdl_wel) $display("FAIL random wel k=%0d: got %b expected %b", k, wel, mdl_wel); else pass_cnt++;
        end
    endtask

    task automatic test_abort();
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: tx_q = '{8'h06};
                1: tx_q = '{8'h02, 8'h00, 8'h00, 8'h40};
                2: tx_q = '{};
                default: tx_q = '{8'h03, 8'h00, 8'h00, 8'h40, 8'h00};
            endcase
            run_txn((k == 1 || k == 2) ? 4 : 0);
            for (int i = 0; i < rx_q.size(); i++) begin
                if (care_q[i]) begin
                    chk_cnt++; if (rx_q[i] !== exp_q[i]) $display("FAIL abort miso k=%0d byte %0d: got %h expected %h", k, i, rx_q[i], exp_q[i]); else pass_cnt++;
                end
            end
            chk_cnt++; if (wel !== mdl_wel) $display("FAIL abort wel k=%0d: got %b expected %b", k, wel, mdl_wel); else pass_cnt++;
            chk_cnt++; if (done_pulses !== exp_done) $display("FAIL abort cmd_done k=%0d: got %0d expected %0d", k, done_pulses, exp_done); else pass_cnt++;
            chk_cnt++; if (miso_oe !== 1'b0) $display("FAIL abort oe k=%0d: got %b expected 0", k, miso_oe); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] r;
        logic       o;
        tx_q = '{8'h06};
        run_txn(0);
        @(negedge clk) cs_n = 1'b0;
        spi_byte(8'h03, 8, r, o);
        spi_byte(8'h00, 8, r, o);
        spi_byte(8'h00, 8, r, o);
        spi_byte(8'h10, 8, r, o);
        spi_byte(8'h00, 3, r, o);
        chk_cnt++; if (miso_oe !== 1'b1) $display("FAIL mid_read oe_before_reset: got %b expected 1", miso_oe); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if ({miso, miso_oe, wel} !== 3'b000) $display("FAIL mid_read reset_outputs: got %b expected 000", {miso, miso_oe, wel}); else pass_cnt++;
        mdl_wel = 1'b0;
        @(negedge clk) cs_n = 1'b1;
        sck = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        tx_q = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
        run_txn(0);
        for (int i = 0; i < rx_q.size(); i++) begin
            if (care_q[i]) begin
                chk_cnt++; if (rx_q[i] !== exp_q[i]) $display("FAIL mid_read reread byte %0d: got %h expected %h", i, rx_q[i], exp_q[i]); else pass_cnt++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mdl_mem[i] = 8'hFF;
        repeat (4) @(negedge clk);
        test_reset();
        test_id_status();
        test_program_read();
        test_read_wrap();
        test_random();
        test_abort();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
